rgb2raw: RTL
============

Name: rgb2raw

Overview:
- Re-mosaicing block (Bayer encoder), the inverse of the raw2rgb demosaic.
- Accepts IN_PCNT RGB pixels per beat with VGA-style timing (vsync/hsync/de/valid) and keeps one colour sample per pixel according to a 2x2 CFA pattern.
- Packs beats into OUT_PCNT raw samples per output beat.
- Used to build sensor-like raw streams from RGB sources, e.g. as a closed-loop stimulus for raw2rgb.

Parameters:
PW, 8, bits per colour sample
IN_PCNT, 2, RGB pixels per input beat; legal values 1, 2, 4
OUT_PCNT, 4, raw samples per output beat; must be IN_PCNT*R with R in {1,2,4}
MAX_HRES, 3840, maximum active pixels per line
MAX_VRES, 2160, maximum active lines per frame
PATTERN, "GBRG", CFA order row0col0,row0col1,row1col0,row1col1; one of "RGGB","GRBG","GBRG","BGGR"

Ports:
i_pclk  in  1  pixel clock
i_rstn  in  1  synchronous active-low reset
i_vsync  in  1  vertical sync, active high
i_hsync  in  1  horizontal sync, active high
i_de  in  1  active-line enable
i_valid  in  1  input beat qualifier, meaningful only while i_de=1
i_r  in  PW*IN_PCNT  red samples; lane 0 (LSBs) is the leftmost pixel
i_g  in  PW*IN_PCNT  green samples
i_b  in  PW*IN_PCNT  blue samples
o_vsync  out  1  i_vsync delayed by 2 cycles
o_hsync  out  1  i_hsync delayed by 2 cycles
o_de  out  1  i_de delayed by 2 cycles, stretched by 1 cycle on a flush
o_valid  out  1  packed raw word valid
o_x_cnt  out  $clog2(MAX_HRES)  output word index within the line
o_y_cnt  out  $clog2(MAX_VRES)  line index within the frame
o_raw  out  PW*OUT_PCNT  packed raw samples; lane 0 is the leftmost pixel

Behaviour:
- Single clock domain, i_pclk. Reset is synchronous and active-low on i_rstn.
- Reset: all outputs are 0; pipeline, gearbox count, pixel-column counter and line counter are cleared.
- A reset asserted mid-line discards any partial word; no flush is emitted.
- Stage A registers all inputs.
- Stage B performs mosaic selection and the gearbox. Output registers follow.
- Data latency is 2 cycles from the input beat that completes a word to o_valid.
- Column parity for lane k = (pixcol + k)[0], where pixcol counts accepted pixels in the line. pixcol clears while i_de=0.
- Row parity = y[0].
- Sample select: R->i_r lane, G->i_g lane, B->i_b lane, per PATTERN at (row parity, column parity).
- Gearbox, with R = OUT_PCNT/IN_PCNT:
  - Beats with de&valid fill slots 0..R-1, earliest beat in the lowest lanes.
  - On the R-th beat, o_valid=1 for exactly one cycle and the slot count resets.
  - With R=1 every valid beat produces an output word.
  - Beats with valid=0 inside de hold the gearbox; no output.
- Flush: when stage-A de falls and the slot count is nonzero:
  - Emit one word with unfilled lanes zero.
  - o_de is held high one extra cycle so that o_valid is never asserted outside o_de.
- o_x_cnt: 0 on the first word of a line, +1 after each o_valid. Cleared while o_de=0.
- Line counter y:
  - Increments on each falling edge of stage-A de.
  - Cleared on the rising edge of stage-A vsync, which takes priority if both occur in the same cycle.
  - Saturates at MAX_VRES-1.
- o_y_cnt is y aligned to the output word.
- pixcol saturates at MAX_HRES-1. Lines longer than this produce undefined parity but no hang.

Optional Feature:
Macro RGB2RAW_CFA_SEL_EN.
- Defined:
  - Adds input port i_pattern [1:0], encoded 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR.
  - The value is sampled on each rising edge of stage-A vsync and held for the frame.
  - On reset it loads the PATTERN parameter encoding; PATTERN is used only as this reset value.
- Undefined: the port does not exist and PATTERN is fixed at elaboration.

Test Plan:
All scenarios use the default parameters with PATTERN "GBRG".
1. Hold i_rstn=0 for 4 cycles with random inputs -> all outputs 0 throughout.
2. Line y=0, two valid beats: beat0 r=11/12, g=21/22, b=31/32; beat1 r=13/14, g=23/24, b=33/34 -> 2 cycles after beat1, o_valid=1 and o_raw lanes 0..3 = 21,32,23,34; o_x_cnt=0.
3. Same stimulus on line y=1 -> o_raw lanes 0..3 = 11,22,13,24; o_y_cnt=1.
4. Line of 3 valid beats -> two words; the second has lanes 2,3 = 0; o_de stays high 1 cycle longer than i_de delayed by 2; o_x_cnt=1 on the second word.
5. Valid-gap line: pattern valid 1,0,0,1 inside de -> exactly one word, emitted 2 cycles after the 4th cycle; no o_valid pulses during the gap.
6. Frame test: 3 lines, then vsync rises, then 1 line -> o_y_cnt 0,1,2, then 0. With RGB2RAW_CFA_SEL_EN, i_pattern=0 sampled at that vsync makes the new frame's line 0 emit R,G,R,G.

Source files
------------

// File: rtl/rgb2raw.sv
// rgb2raw: Bayer re-mosaic encoder. Keeps one colour per pixel according to a 2x2 CFA
// pattern and packs IN_PCNT-pixel beats into OUT_PCNT-sample raw words.
// Optional macro RGB2RAW_CFA_SEL_EN adds a runtime i_pattern input sampled at each frame start.
// Handshake: a beat is accepted when de & valid are both high; o_valid pulses for one cycle per word
// and is only ever asserted while o_de is high. There is no backpressure.
module rgb2raw #(
  parameter int          PW       = 8,
  parameter int          IN_PCNT  = 2,
  parameter int          OUT_PCNT = 4,
  parameter int          MAX_HRES = 3840,
  parameter int          MAX_VRES = 2160,
  parameter logic [31:0] PATTERN  = "GBRG"
) (
  input  logic                          i_pclk,
  input  logic                          i_rstn,
  input  logic                          i_vsync,
  input  logic                          i_hsync,
  input  logic                          i_de,
  input  logic                          i_valid,
`ifdef RGB2RAW_CFA_SEL_EN
  input  logic [1:0]                    i_pattern,
`endif
  input  logic [PW*IN_PCNT-1:0]         i_r,
  input  logic [PW*IN_PCNT-1:0]         i_g,
  input  logic [PW*IN_PCNT-1:0]         i_b,
  output logic                          o_vsync,
  output logic                          o_hsync,
  output logic                          o_de,
  output logic                          o_valid,
  output logic [$clog2(MAX_HRES)-1:0]   o_x_cnt,
  output logic [$clog2(MAX_VRES)-1:0]   o_y_cnt,
  output logic [PW*OUT_PCNT-1:0]        o_raw
);

  localparam int R      = OUT_PCNT / IN_PCNT;
  localparam int SLOT_W = (R > 1) ? $clog2(R) : 1;
  localparam int XW     = $clog2(MAX_HRES);
  localparam int YW     = $clog2(MAX_VRES);
  localparam int PCW    = XW + 1;
  localparam int IW     = PW * IN_PCNT;
  localparam int OW     = PW * OUT_PCNT;

  localparam logic [1:0] PAT_ENC = (PATTERN == "RGGB") ? 2'd0 :
                                   (PATTERN == "GRBG") ? 2'd1 :
                                   (PATTERN == "GBRG") ? 2'd2 : 2'd3;

  // Colour at a CFA site: 0=R, 1=G, 2=B. Green sits on the diagonal whose
  // (row^col) differs from pat[0]^pat[1]; red occupies the row pat[1].
  function automatic logic [1:0] cfa_color(input logic [1:0] pat, input logic row,
                                           input logic col);
    logic [1:0] c;
    if ((row ^ col) != (pat[0] ^ pat[1])) c = 2'd1;
    else if (row == pat[1])               c = 2'd0;
    else                                  c = 2'd2;
    return c;
  endfunction

  // Stage A registers
  logic              r_a_vs;
  logic              r_a_hs;
  logic              r_a_de;
  logic              r_a_valid;
  logic [IW-1:0]     r_a_r;
  logic [IW-1:0]     r_a_g;
  logic [IW-1:0]     r_a_b;
  logic              r_a_vs_d;
  logic              r_a_de_d;

  // Stage B state
  logic [SLOT_W-1:0] r_slot;
  logic [OW-1:0]     r_acc;
  logic [PCW-1:0]    r_pixcol;
  logic [YW-1:0]     r_y;
  logic [XW-1:0]     r_wcnt;

  logic [1:0]        w_pat;
  logic              w_beat;
  logic              w_de_fall;
  logic              w_vs_rise;
  logic              w_flush;
  logic              w_last;
  logic              w_emit;
  logic              w_de_out;
  logic [IW-1:0]     w_sel;
  logic [OW-1:0]     w_ext;
  logic [OW-1:0]     w_ins;
  logic [OW-1:0]     w_word;
  logic [PCW-1:0]    w_pix_sum;
  logic [PCW-1:0]    w_pix_next;

`ifdef RGB2RAW_CFA_SEL_EN
  logic [1:0] r_a_pat;
  logic [1:0] r_pat;

  always_ff @(posedge i_pclk) begin
    if (!i_rstn) begin
      r_a_pat <= 2'd0;
      r_pat   <= PAT_ENC;
    end else begin
      r_a_pat <= i_pattern;
      if (w_vs_rise) r_pat <= r_a_pat;
    end
  end

  assign w_pat = r_pat;
`else
  assign w_pat = PAT_ENC;
`endif

  assign w_beat    = r_a_de & r_a_valid;
  assign w_de_fall = r_a_de_d & ~r_a_de;
  assign w_vs_rise = r_a_vs & ~r_a_vs_d;
  assign w_flush   = w_de_fall & (r_slot != '0);
  assign w_last    = w_beat & (r_slot == SLOT_W'(R - 1));
  assign w_emit    = w_last | w_flush;
  assign w_de_out  = r_a_de | w_flush;

  assign w_pix_sum  = r_pixcol + PCW'(IN_PCNT);
  assign w_pix_next = (w_pix_sum > PCW'(MAX_HRES - 1)) ? PCW'(MAX_HRES - 1) : w_pix_sum;

  always_comb begin
    w_sel = '0;
    for (int k = 0; k < IN_PCNT; k++) begin
      case (cfa_color(w_pat, r_y[0], r_pixcol[0] ^ k[0]))
        2'd0:    w_sel[k*PW +: PW] = r_a_r[k*PW +: PW];
        2'd1:    w_sel[k*PW +: PW] = r_a_g[k*PW +: PW];
        default: w_sel[k*PW +: PW] = r_a_b[k*PW +: PW];
      endcase
    end
  end

  // Earliest beat lands in the lowest lanes of the output word.
  always_comb begin
    w_ext         = '0;
    w_ext[IW-1:0] = w_sel;
    w_ins         = w_ext << (IW * int'(r_slot));
    w_word        = r_acc | w_ins;
  end

  always_ff @(posedge i_pclk) begin
    if (!i_rstn) begin
      r_a_vs    <= 1'b0;
      r_a_hs    <= 1'b0;
      r_a_de    <= 1'b0;
      r_a_valid <= 1'b0;
      r_a_r     <= '0;
      r_a_g     <= '0;
      r_a_b     <= '0;
      r_a_vs_d  <= 1'b0;
      r_a_de_d  <= 1'b0;
    end else begin
      r_a_vs    <= i_vsync;
      r_a_hs    <= i_hsync;
      r_a_de    <= i_de;
      r_a_valid <= i_valid;
      r_a_r     <= i_r;
      r_a_g     <= i_g;
      r_a_b     <= i_b;
      r_a_vs_d  <= r_a_vs;
      r_a_de_d  <= r_a_de;
    end
  end

  always_ff @(posedge i_pclk) begin
    if (!i_rstn) begin
      r_slot   <= '0;
      r_acc    <= '0;
      r_pixcol <= '0;
      r_y      <= '0;
    end else begin
      if (w_beat) begin
        if (w_last) begin
          r_slot <= '0;
          r_acc  <= '0;
        end else begin
          r_slot <= r_slot + SLOT_W'(1);
          r_acc  <= w_word;
        end
      end else if (w_flush) begin
        r_slot <= '0;
        r_acc  <= '0;
      end

      if (!r_a_de)     r_pixcol <= '0;
      else if (w_beat) r_pixcol <= w_pix_next;

      // Frame start wins over an end-of-line in the same cycle.
      if (w_vs_rise)
        r_y <= '0;
      else if (w_de_fall && (r_y != YW'(MAX_VRES - 1)))
        r_y <= r_y + YW'(1);
    end
  end

  always_ff @(posedge i_pclk) begin
    if (!i_rstn) begin
      o_vsync <= 1'b0;
      o_hsync <= 1'b0;
      o_de    <= 1'b0;
      o_valid <= 1'b0;
      o_raw   <= '0;
      o_x_cnt <= '0;
      o_y_cnt <= '0;
      r_wcnt  <= '0;
    end else begin
      o_vsync <= r_a_vs;
      o_hsync <= r_a_hs;
      o_de    <= w_de_out;
      o_valid <= w_emit;
      o_y_cnt <= r_y;
      if (w_emit) o_raw <= w_last ? w_word : r_acc;
      if (!w_de_out) begin
        o_x_cnt <= '0;
        r_wcnt  <= '0;
      end else if (w_emit) begin
        o_x_cnt <= r_wcnt;
        r_wcnt  <= r_wcnt + XW'(1);
      end
    end
  end

endmodule
